// File: rtl/bank_arb_pkg.sv
// bank_arb_pkg: shared types and constants for the HIRAM bank arbiter.
//   gnt_e      - grant recorded in the previous cycle; selects which read port
//                captures MEM_DOUT in the current cycle.
//   RUN_CNT_W  - width of the consecutive-GFX-grant counter.
//   STAT_W     - width of the optional stall statistics counter.
package bank_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_CPU_RD = 2'd1,
    GNT_GFX    = 2'd2
  } gnt_e;

  localparam int RUN_CNT_W = 4;
  localparam int STAT_W    = 16;

endpackage

// File: rtl/bank_arbiter.sv
// bank_arbiter: shares one single-port, synchronous-read RAM bank between the
// CPU port and the GFX scanout read port. One instance per HIRAM bank.
//
// GFX has fixed priority. A run counter limits GFX to MAX_GFX_RUN consecutive
// grants while the CPU is waiting, then forces one CPU slot. The grant is
// combinational, so an uncontested request is served in the cycle it appears
// and the port sees BUSY=0. Read data returns one cycle after the grant on
// both ports (VALID pulses in that cycle, DOUT shows the new word from that
// cycle on and holds it afterwards).
//
// Ports:
//   CLK, RSTb                 clock, synchronous active-low reset
//   CPU_ADDR/DIN/RD/WR        CPU request (held until granted); RD+WR = write
//   CPU_BUSY/DOUT/VALID       CPU stall (to memBUSY), read data, read strobe
//   GFX_ADDR/RD               GFX read request (held until granted)
//   GFX_BUSY/DOUT/VALID       GFX stall, read data, read strobe
//   MEM_ADDR/DIN/WR, MEM_DOUT RAM interface; MEM_DOUT valid 1 cycle after addr
//
// Optional build macro BANK_ARBITER_STATS_EN adds STAT_CLR (in) and
// STAT_STALLS[15:0] (out): a saturating count of CPU_BUSY cycles, cleared by
// STAT_CLR (clear wins over increment).
module bank_arbiter
  import bank_arb_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 14,
  parameter int MAX_GFX_RUN  = 4
) (
  input  logic                    CLK,
  input  logic                    RSTb,
`ifdef BANK_ARBITER_STATS_EN
  input  logic                    STAT_CLR,
  output logic [STAT_W-1:0]       STAT_STALLS,
`endif
  input  logic [ADDRESS_BITS-1:0] CPU_ADDR,
  input  logic [BITS-1:0]         CPU_DIN,
  input  logic                    CPU_RD,
  input  logic                    CPU_WR,
  output logic                    CPU_BUSY,
  output logic [BITS-1:0]         CPU_DOUT,
  output logic                    CPU_VALID,
  input  logic [ADDRESS_BITS-1:0] GFX_ADDR,
  input  logic                    GFX_RD,
  output logic                    GFX_BUSY,
  output logic [BITS-1:0]         GFX_DOUT,
  output logic                    GFX_VALID,
  output logic [ADDRESS_BITS-1:0] MEM_ADDR,
  output logic [BITS-1:0]         MEM_DIN,
  output logic                    MEM_WR,
  input  logic [BITS-1:0]         MEM_DOUT
);

  localparam logic [RUN_CNT_W-1:0] RUN_LIMIT = RUN_CNT_W'(MAX_GFX_RUN);
  localparam logic [RUN_CNT_W-1:0] RUN_MAX   = '1;

  logic                    cpu_req;
  logic                    gfx_gnt;
  logic                    cpu_gnt;

  gnt_e                    last_gnt_d, last_gnt_q;
  logic [RUN_CNT_W-1:0]    run_cnt_d, run_cnt_q;
  logic [ADDRESS_BITS-1:0] mem_addr_d, mem_addr_q;
  logic [BITS-1:0]         cpu_dout_d, cpu_dout_q;
  logic [BITS-1:0]         gfx_dout_d, gfx_dout_q;

  always_comb begin
    cpu_req = CPU_RD | CPU_WR;
    // GFX wins unless the CPU has already waited through a full GFX run.
    gfx_gnt = GFX_RD && !(cpu_req && (run_cnt_q == RUN_LIMIT));
    cpu_gnt = cpu_req && !gfx_gnt;

    CPU_BUSY = cpu_req && !cpu_gnt;
    GFX_BUSY = GFX_RD && !gfx_gnt;

    // RAM side. Without a grant the address bus parks on its last value.
    mem_addr_d = mem_addr_q;
    if (gfx_gnt)      mem_addr_d = GFX_ADDR;
    else if (cpu_gnt) mem_addr_d = CPU_ADDR;
    MEM_ADDR = mem_addr_d;
    MEM_DIN  = cpu_gnt ? CPU_DIN : '0;
    MEM_WR   = cpu_gnt && CPU_WR;

    // A combined RD+WR is treated as a write, so it never produces read data.
    last_gnt_d = GNT_NONE;
    if (gfx_gnt)                 last_gnt_d = GNT_GFX;
    else if (cpu_gnt && !CPU_WR) last_gnt_d = GNT_CPU_RD;

    // Run length only counts GFX grants that actually delayed the CPU.
    run_cnt_d = run_cnt_q;
    if (cpu_gnt || !cpu_req)             run_cnt_d = '0;
    else if (gfx_gnt && run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + 1'b1;

    // Strobes are masked in reset so a read in flight when reset hits is dropped.
    CPU_VALID = RSTb && (last_gnt_q == GNT_CPU_RD);
    GFX_VALID = RSTb && (last_gnt_q == GNT_GFX);

    // DOUT follows the RAM during the strobe cycle, then holds the captured word.
    cpu_dout_d = CPU_VALID ? MEM_DOUT : cpu_dout_q;
    gfx_dout_d = GFX_VALID ? MEM_DOUT : gfx_dout_q;
    CPU_DOUT   = cpu_dout_d;
    GFX_DOUT   = gfx_dout_d;
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      last_gnt_q <= GNT_NONE;
      run_cnt_q  <= '0;
      mem_addr_q <= '0;
      cpu_dout_q <= '0;
      gfx_dout_q <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      run_cnt_q  <= run_cnt_d;
      mem_addr_q <= mem_addr_d;
      cpu_dout_q <= cpu_dout_d;
      gfx_dout_q <= gfx_dout_d;
    end
  end

`ifdef BANK_ARBITER_STATS_EN
  logic [STAT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (STAT_CLR)                             stall_cnt_d = '0;
    else if (CPU_BUSY && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + 1'b1;
    STAT_STALLS = stall_cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end
`endif

endmodule

// File: tb/tb_bank_arbiter.sv
// tb_bank_arbiter: directed, table-driven bench for bank_arbiter with a
// behavioural sync-read RAM (unwritten word at address a reads 0x1000 + a).
module tb_bank_arbiter;

  localparam int BITS = 16;
  localparam int AB   = 14;

  logic            CLK = 1'b0;
  logic            RSTb;
  logic [AB-1:0]   CPU_ADDR, GFX_ADDR, MEM_ADDR;
  logic [BITS-1:0] CPU_DIN, CPU_DOUT, GFX_DOUT, MEM_DIN;
  logic [BITS-1:0] MEM_DOUT;
  logic            CPU_RD, CPU_WR, CPU_BUSY, CPU_VALID;
  logic            GFX_RD, GFX_BUSY, GFX_VALID, MEM_WR;
`ifdef BANK_ARBITER_STATS_EN
  logic            STAT_CLR;
  logic [15:0]     STAT_STALLS;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  bank_arbiter #(.BITS(BITS), .ADDRESS_BITS(AB), .MAX_GFX_RUN(4)) dut (
    .CLK(CLK), .RSTb(RSTb),
`ifdef BANK_ARBITER_STATS_EN
    .STAT_CLR(STAT_CLR), .STAT_STALLS(STAT_STALLS),
`endif
    .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR),
    .CPU_BUSY(CPU_BUSY), .CPU_DOUT(CPU_DOUT), .CPU_VALID(CPU_VALID),
    .GFX_ADDR(GFX_ADDR), .GFX_RD(GFX_RD), .GFX_BUSY(GFX_BUSY),
    .GFX_DOUT(GFX_DOUT), .GFX_VALID(GFX_VALID),
    .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_WR(MEM_WR), .MEM_DOUT(MEM_DOUT)
  );

  // Sync-read RAM model
  logic [BITS-1:0] ram [0:(1<<AB)-1];
  logic            ram_init = 1'b0;
  always @(posedge CLK) begin
    if (!ram_init) begin
      for (int i = 0; i < (1<<AB); i++) ram[i] <= 16'h1000 + 16'(i);
      ram_init <= 1'b1;
      MEM_DOUT <= '0;
    end else begin
      if (MEM_WR) ram[MEM_ADDR] <= MEM_DIN;
      MEM_DOUT <= ram[MEM_ADDR];
    end
  end

  typedef struct {
    logic          rd, wr, grd;
    logic [AB-1:0] ca, ga;
    logic [15:0]   din;
    logic          e_cb, e_gb, e_mwr;
    logic [AB-1:0] e_ma;
    logic          e_cv, e_gv;
    logic [15:0]   e_cd, e_gd;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    CPU_RD = 1'b0; CPU_WR = 1'b0; GFX_RD = 1'b0;
    CPU_ADDR = '0; GFX_ADDR = '0; CPU_DIN = '0;
  endtask

  initial begin
    // rd wr grd  ca       ga       din       cb gb mwr ma        cv gv cd        gd
    vecs[0]  = '{0,0,0, 14'h0000,14'h0000,16'h0000, 0,0,0, 14'h0000, 0,0,16'h0000,16'h0000};
    vecs[1]  = '{0,1,0, 14'h0010,14'h0000,16'hBEEF, 0,0,1, 14'h0010, 0,0,16'h0000,16'h0000};
    vecs[2]  = '{0,0,0, 14'h0000,14'h0000,16'h0000, 0,0,0, 14'h0010, 0,0,16'h0000,16'h0000};
    vecs[3]  = '{1,0,0, 14'h0010,14'h0000,16'h0000, 0,0,0, 14'h0010, 1,0,16'hBEEF,16'h0000};
    vecs[4]  = '{0,0,1, 14'h0000,14'h0200,16'h0000, 0,0,0, 14'h0200, 0,1,16'h0000,16'h1200};
    vecs[5]  = '{1,0,1, 14'h0011,14'h0201,16'h0000, 1,0,0, 14'h0201, 0,1,16'h0000,16'h1201};
    vecs[6]  = '{0,1,1, 14'h0022,14'h0300,16'h5555, 1,0,0, 14'h0300, 0,1,16'h0000,16'h1300};
    vecs[7]  = '{1,1,0, 14'h3FFF,14'h0000,16'h1234, 0,0,1, 14'h3FFF, 0,0,16'h0000,16'h0000};
    vecs[8]  = '{0,0,0, 14'h0000,14'h0000,16'h0000, 0,0,0, 14'h3FFF, 0,0,16'h0000,16'h0000};
    vecs[9]  = '{1,0,0, 14'h3FFF,14'h0000,16'h0000, 0,0,0, 14'h3FFF, 1,0,16'h1234,16'h0000};
    vecs[10] = '{1,0,0, 14'h0022,14'h0000,16'h0000, 0,0,0, 14'h0022, 1,0,16'h1022,16'h0000};

    idle();
`ifdef BANK_ARBITER_STATS_EN
    STAT_CLR = 1'b0;
`endif
    RSTb = 1'b0;
    repeat (3) step();
    RSTb = 1'b1;
    #1;
    check("rst_cpu_valid", 32'(CPU_VALID), 0);
    check("rst_gfx_valid", 32'(GFX_VALID), 0);
    check("rst_cpu_dout",  32'(CPU_DOUT), 0);
    check("rst_gfx_dout",  32'(GFX_DOUT), 0);
    check("rst_mem_addr",  32'(MEM_ADDR), 0);
    check("rst_busy",      32'({CPU_BUSY, GFX_BUSY, MEM_WR}), 0);
`ifdef BANK_ARBITER_STATS_EN
    check("rst_stalls",    32'(STAT_STALLS), 0);
`endif
    step();

    // Single-cycle vectors, each followed by an idle cycle that shows the read result
    for (int i = 0; i < 11; i++) begin
      CPU_RD = vecs[i].rd; CPU_WR = vecs[i].wr; GFX_RD = vecs[i].grd;
      CPU_ADDR = vecs[i].ca; GFX_ADDR = vecs[i].ga; CPU_DIN = vecs[i].din;
      #1;
      check($sformatf("v%0d_cpu_busy", i), 32'(CPU_BUSY), 32'(vecs[i].e_cb));
      check($sformatf("v%0d_gfx_busy", i), 32'(GFX_BUSY), 32'(vecs[i].e_gb));
      check($sformatf("v%0d_mem_wr", i),   32'(MEM_WR),   32'(vecs[i].e_mwr));
      check($sformatf("v%0d_mem_addr", i), 32'(MEM_ADDR), 32'(vecs[i].e_ma));
      if (vecs[i].e_mwr) check($sformatf("v%0d_mem_din", i), 32'(MEM_DIN), 32'(vecs[i].din));
      step();
      idle();
      #1;
      check($sformatf("v%0d_cpu_valid", i), 32'(CPU_VALID), 32'(vecs[i].e_cv));
      check($sformatf("v%0d_gfx_valid", i), 32'(GFX_VALID), 32'(vecs[i].e_gv));
      if (vecs[i].e_cv) check($sformatf("v%0d_cpu_dout", i), 32'(CPU_DOUT), 32'(vecs[i].e_cd));
      if (vecs[i].e_gv) check($sformatf("v%0d_gfx_dout", i), 32'(GFX_DOUT), 32'(vecs[i].e_gd));
      step();
    end

    // Contention: GFX first, CPU next cycle, then CPU data
    CPU_RD = 1'b1; CPU_ADDR = 14'h0010; GFX_RD = 1'b1; GFX_ADDR = 14'h0201;
    #1;
    check("c2_cpu_busy0", 32'(CPU_BUSY), 1);
    check("c2_mem_addr0", 32'(MEM_ADDR), 32'h0201);
    step();
    GFX_RD = 1'b0;
    #1;
    check("c2_cpu_busy1",  32'(CPU_BUSY), 0);
    check("c2_gfx_valid1", 32'(GFX_VALID), 1);
    check("c2_gfx_dout1",  32'(GFX_DOUT), 32'h1201);
    check("c2_cpu_valid1", 32'(CPU_VALID), 0);
    step();
    idle();
    #1;
    check("c2_cpu_valid2", 32'(CPU_VALID), 1);
    check("c2_cpu_dout2",  32'(CPU_DOUT), 32'hBEEF);
    check("c2_gfx_valid2", 32'(GFX_VALID), 0);
    check("c2_gfx_hold2",  32'(GFX_DOUT), 32'h1201);
    step();

    // Starvation guard: 4 GFX grants then one CPU grant, repeating
    CPU_RD = 1'b1; CPU_ADDR = 14'h0005; GFX_RD = 1'b1; GFX_ADDR = 14'h0100;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("c3_cpu_busy%0d", c), 32'(CPU_BUSY), (c % 5 == 4) ? 0 : 1);
      check($sformatf("c3_gfx_busy%0d", c), 32'(GFX_BUSY), (c % 5 == 4) ? 1 : 0);
      step();
    end
    idle();
    step();

    // Reset in the cycle after a GFX grant, with a partial GFX run built up
    CPU_RD = 1'b1; CPU_ADDR = 14'h0005; GFX_RD = 1'b1; GFX_ADDR = 14'h0202;
    step();
    step();
    RSTb = 1'b0;
    #1;
    check("c5_gfx_valid_rst", 32'(GFX_VALID), 0);
    step();
    RSTb = 1'b1;
    #1;
    check("c5_gfx_valid_rel", 32'(GFX_VALID), 0);
    check("c5_gfx_dout_rel",  32'(GFX_DOUT), 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("c5_cpu_busy%0d", c), 32'(CPU_BUSY), (c == 4) ? 0 : 1);
      step();
    end
    idle();
    step();

`ifdef BANK_ARBITER_STATS_EN
    STAT_CLR = 1'b1;
    step();
    STAT_CLR = 1'b0;
    CPU_RD = 1'b1; GFX_RD = 1'b1;
    repeat (12) step();
    idle();
    #1;
    check("c6_stalls10", 32'(STAT_STALLS), 10);
    CPU_RD = 1'b1; GFX_RD = 1'b1; STAT_CLR = 1'b1;
    #1;
    check("c6_stall_now", 32'(CPU_BUSY), 1);
    step();
    STAT_CLR = 1'b0;
    idle();
    #1;
    check("c6_clr_wins", 32'(STAT_STALLS), 0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
